// File: rtl/chs_fan_pwm_array.sv
// Multi-channel fan PWM generator. Each channel ramps its applied duty toward its target.
// Optional kick-start at full duty from OFF is enabled by defining CHS_KICKSTART_EN.
module chs_fan_pwm_array #(
   parameter int CH           = 2,
   parameter int WIDTH        = 8,
   parameter int STEP         = 4,
   parameter int RAMP_PERIODS = 4,
   parameter int KICK_PERIODS = 8
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic [CH-1:0]         en,
   input  logic [CH*WIDTH-1:0]   speed,
   output logic [CH-1:0]         pwm_data,
   output logic [CH*WIDTH-1:0]   duty,
   output logic [CH-1:0]         busy,
   output logic                  period_tick
);

   localparam logic [WIDTH-1:0] MAX_V    = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};
   localparam logic [WIDTH-1:0] STEP_V   = WIDTH'(STEP);
   localparam int               RW       = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
   localparam logic [RW-1:0]    RAMP_LAST = RW'(RAMP_PERIODS - 1);

`ifdef CHS_KICKSTART_EN
   localparam int               KW        = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
   localparam logic [KW-1:0]    KICK_LAST = KW'(KICK_PERIODS - 1);

   typedef enum logic [2:0] {
      ST_OFF    = 3'd0,
      ST_UP     = 3'd1,
      ST_DOWN   = 3'd2,
      ST_STEADY = 3'd3,
      ST_KICK   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_OFF    = 3'd0,
      ST_UP     = 3'd1,
      ST_DOWN   = 3'd2,
      ST_STEADY = 3'd3
   } state_t;
`endif

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [RW-1:0]    ramp_q, ramp_d;
   logic             ramp_tick;
   state_t           state_q [CH];
   state_t           state_d [CH];
   logic [WIDTH-1:0] duty_q  [CH];
   logic [WIDTH-1:0] duty_d  [CH];
   logic [WIDTH-1:0] tgt     [CH];
   logic [WIDTH-1:0] nxt     [CH];
   logic [CH-1:0]    pwm_q, pwm_d;
`ifdef CHS_KICKSTART_EN
   logic [KW-1:0]    kick_q  [CH];
   logic [KW-1:0]    kick_d  [CH];
   logic [WIDTH-1:0] first   [CH];
`endif

   // One step toward tgt, clamped by the remaining gap so the target is never overshot.
   function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                    input logic [WIDTH-1:0] goal);
      logic             up;
      logic [WIDTH-1:0] gap;
      logic [WIDTH-1:0] inc;
      logic [WIDTH:0]   wide;
      up   = (goal > cur);
      gap  = up ? (goal - cur) : (cur - goal);
      inc  = (gap < STEP_V) ? gap : STEP_V;
      wide = up ? ({1'b0, cur} + {1'b0, inc}) : ({1'b0, cur} - {1'b0, inc});
      if (wide > {1'b0, MAX_V}) begin
         step_toward = up ? MAX_V : '0;
      end else begin
         step_toward = wide[WIDTH-1:0];
      end
   endfunction

   always_comb begin
      period_tick = (cnt_q == CNT_LAST);
      cnt_d       = period_tick ? '0 : cnt_q + 1'b1;
      ramp_tick   = period_tick && (ramp_q == RAMP_LAST);
      ramp_d      = ramp_q;
      if (period_tick) begin
         ramp_d = ramp_tick ? '0 : ramp_q + 1'b1;
      end
   end

   // Duty only moves on period boundaries, so every PWM period is whole.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         state_d[i] = state_q[i];
         duty_d[i]  = duty_q[i];
         tgt[i]     = en[i] ? speed[i*WIDTH +: WIDTH] : '0;
         nxt[i]     = step_toward(duty_q[i], tgt[i]);
         pwm_d[i]   = (cnt_q < duty_q[i]);
`ifdef CHS_KICKSTART_EN
         kick_d[i]  = kick_q[i];
         first[i]   = (tgt[i] < STEP_V) ? tgt[i] : STEP_V;
`endif
         case (state_q[i])
            ST_OFF: begin
               if (ramp_tick) begin
                  duty_d[i] = '0;
                  if (tgt[i] != '0) begin
`ifdef CHS_KICKSTART_EN
                     state_d[i] = ST_KICK;
                     duty_d[i]  = MAX_V;
                     kick_d[i]  = '0;
`else
                     state_d[i] = ST_UP;
`endif
                  end
               end
            end
`ifdef CHS_KICKSTART_EN
            ST_KICK: begin
               if (period_tick) begin
                  if (tgt[i] == '0) begin
                     state_d[i] = ST_OFF;
                     duty_d[i]  = '0;
                  end else if (kick_q[i] == KICK_LAST) begin
                     duty_d[i]  = first[i];
                     state_d[i] = (first[i] == tgt[i]) ? ST_STEADY : ST_UP;
                  end else begin
                     kick_d[i] = kick_q[i] + 1'b1;
                  end
               end
            end
`endif
            default: begin
               // UP, DOWN and STEADY share one rule: direction is re-derived every tick.
               if (ramp_tick) begin
                  duty_d[i] = nxt[i];
                  if (nxt[i] == tgt[i]) begin
                     state_d[i] = (tgt[i] == '0) ? ST_OFF : ST_STEADY;
                  end else if (tgt[i] > duty_q[i]) begin
                     state_d[i] = ST_UP;
                  end else begin
                     state_d[i] = ST_DOWN;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         cnt_q  <= '0;
         ramp_q <= '0;
         pwm_q  <= '0;
         for (int i = 0; i < CH; i++) begin
            state_q[i] <= ST_OFF;
            duty_q[i]  <= '0;
`ifdef CHS_KICKSTART_EN
            kick_q[i]  <= '0;
`endif
         end
      end else begin
         cnt_q  <= cnt_d;
         ramp_q <= ramp_d;
         pwm_q  <= pwm_d;
         for (int i = 0; i < CH; i++) begin
            state_q[i] <= state_d[i];
            duty_q[i]  <= duty_d[i];
`ifdef CHS_KICKSTART_EN
            kick_q[i]  <= kick_d[i];
`endif
         end
      end
   end

   always_comb begin
      pwm_data = pwm_q;
      duty     = '0;
      busy     = '0;
      for (int i = 0; i < CH; i++) begin
         duty[i*WIDTH +: WIDTH] = duty_q[i];
`ifdef CHS_KICKSTART_EN
         busy[i] = (state_q[i] == ST_UP) || (state_q[i] == ST_DOWN) || (state_q[i] == ST_KICK);
`else
         busy[i] = (state_q[i] == ST_UP) || (state_q[i] == ST_DOWN);
`endif
      end
   end

endmodule

// File: tb/tb_chs_fan_pwm_array.sv
// Directed bench for chs_fan_pwm_array at default parameters (CH=2, WIDTH=8, STEP=4, RAMP_PERIODS=4).
module tb_chs_fan_pwm_array;

   logic        clk = 1'b0;
   logic        arst = 1'b0;
   logic [1:0]  en = 2'b00;
   logic [15:0] speed = 16'h0000;
   logic [1:0]  pwm_data;
   logic [15:0] duty;
   logic [1:0]  busy;
   logic        period_tick;

   int n_tests = 0;
   int n_fail  = 0;
   int pt_cnt  = 0;
   int cyc;
   int hi;

   chs_fan_pwm_array dut (
      .clk        (clk),
      .arst       (arst),
      .en         (en),
      .speed      (speed),
      .pwm_data   (pwm_data),
      .duty       (duty),
      .busy       (busy),
      .period_tick(period_tick)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Every clock the bench advances goes through here so period ticks are never missed.
   task automatic step_clk();
      @(negedge clk);
      if (period_tick) pt_cnt++;
   endtask

   task automatic wait_ptick();
      int k;
      k = 0;
      do begin
         step_clk();
         k++;
      end while (!period_tick && k < 300);
      if (!period_tick) check_eq("ptick_timeout", 32'd0, 32'd1);
   endtask

   // Advance to the next ramp tick (every 4th period tick since reset), then one clock
   // further so the newly registered duty/state is visible.
   task automatic wait_ramp();
      int g;
      g = 0;
      do begin
         wait_ptick();
         g++;
      end while ((pt_cnt % 4) != 0 && g < 8);
      if ((pt_cnt % 4) != 0) check_eq("ramp_timeout", 32'd0, 32'd1);
      step_clk();
   endtask

   task automatic check_ramp(input string tag, input logic [7:0] d0, input logic b0,
                             input logic [7:0] d1, input logic b1);
      wait_ramp();
      check_eq({tag, "_duty0"}, {24'd0, duty[7:0]}, {24'd0, d0});
      check_eq({tag, "_busy0"}, {31'd0, busy[0]}, {31'd0, b0});
      check_eq({tag, "_duty1"}, {24'd0, duty[15:8]}, {24'd0, d1});
      check_eq({tag, "_busy1"}, {31'd0, busy[1]}, {31'd0, b1});
   endtask

   task automatic count_high(input int ch, output int n);
      n = 0;
      repeat (255) begin
         step_clk();
         if (pwm_data[ch]) n++;
      end
   endtask

   task automatic first_tick_after_release(input string tag);
      cyc = 0;
      do begin
         step_clk();
         cyc++;
      end while (!period_tick && cyc < 400);
      // cnt=254 is reached 254 clocks after release, i.e. on the 255th clock.
      check_eq(tag, cyc, 32'd254);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_eq("rst_pwm", {30'd0, pwm_data}, 32'd0);
      check_eq("rst_duty", {16'd0, duty}, 32'd0);
      check_eq("rst_busy", {30'd0, busy}, 32'd0);
      check_eq("rst_ptick", {31'd0, period_tick}, 32'd0);

      arst   = 1'b1;
      pt_cnt = 0;
      first_tick_after_release("first_ptick_cycle");

      // Ramp up ch0 to 0x10: OFF->UP tick, then 4,8,12,16.
      en    = 2'b01;
      speed = {8'h00, 8'h10};
      check_ramp("up0", 8'd0, 1'b1, 8'd0, 1'b0);
      check_ramp("up1", 8'd4, 1'b1, 8'd0, 1'b0);
      check_ramp("up2", 8'd8, 1'b1, 8'd0, 1'b0);
      check_ramp("up3", 8'd12, 1'b1, 8'd0, 1'b0);
      check_ramp("up4", 8'd16, 1'b0, 8'd0, 1'b0);
      count_high(0, hi);
      check_eq("pwm0_high_16", hi, 32'd16);
      count_high(1, hi);
      check_eq("pwm1_off", hi, 32'd0);

      // A change between ramp ticks must not move the duty at a plain period tick.
      en    = 2'b11;
      speed = {8'h0A, 8'h0A};
      wait_ptick();
      step_clk();
      check_eq("no_early_duty0", {24'd0, duty[7:0]}, 32'd16);
      check_eq("no_early_duty1", {24'd0, duty[15:8]}, 32'd0);

      // ch0 ramps down 16->12->10 while ch1 ramps up 0,4,8,10 (no overshoot past 0x0A).
      check_ramp("ind0", 8'd12, 1'b1, 8'd0, 1'b1);
      check_ramp("ind1", 8'd10, 1'b0, 8'd4, 1'b1);
      check_ramp("ind2", 8'd10, 1'b0, 8'd8, 1'b1);
      check_ramp("ind3", 8'd10, 1'b0, 8'd10, 1'b0);

      // Reversal mid-ramp: heading to 0x40, then target drops to 0x10.
      speed = {8'h0A, 8'h40};
      check_ramp("rev0", 8'd14, 1'b1, 8'd10, 1'b0);
      check_ramp("rev1", 8'd18, 1'b1, 8'd10, 1'b0);
      check_ramp("rev2", 8'd22, 1'b1, 8'd10, 1'b0);
      speed = {8'h0A, 8'h10};
      check_ramp("rev3", 8'd18, 1'b1, 8'd10, 1'b0);

      // Disable ch0: ramps down to zero, then OFF.
      en = 2'b10;
      check_ramp("dis0", 8'd14, 1'b1, 8'd10, 1'b0);
      check_ramp("dis1", 8'd10, 1'b1, 8'd10, 1'b0);
      check_ramp("dis2", 8'd6, 1'b1, 8'd10, 1'b0);
      check_ramp("dis3", 8'd2, 1'b1, 8'd10, 1'b0);
      check_ramp("dis4", 8'd0, 1'b0, 8'd10, 1'b0);
      count_high(0, hi);
      check_eq("pwm0_const_low", hi, 32'd0);
      count_high(1, hi);
      check_eq("pwm1_high_10", hi, 32'd10);

      // Restart ch0 toward 0x40, then reset in the middle of the ramp.
      en    = 2'b11;
      speed = {8'h0A, 8'h40};
      check_ramp("pre0", 8'd0, 1'b1, 8'd10, 1'b0);
      check_ramp("pre1", 8'd4, 1'b1, 8'd10, 1'b0);
      check_ramp("pre2", 8'd8, 1'b1, 8'd10, 1'b0);
      step_clk();
      check_eq("pre_rst_pwm", {30'd0, pwm_data}, 32'd3);

      #2 arst = 1'b0;
      #1;
      check_eq("mid_rst_pwm", {30'd0, pwm_data}, 32'd0);
      check_eq("mid_rst_duty", {16'd0, duty}, 32'd0);
      check_eq("mid_rst_busy", {30'd0, busy}, 32'd0);
      @(negedge clk);
      arst   = 1'b1;
      pt_cnt = 0;
      first_tick_after_release("rel_ptick_cycle");

      // Both channels restart from OFF after release.
      check_ramp("post0", 8'd0, 1'b1, 8'd0, 1'b1);
      check_ramp("post1", 8'd4, 1'b1, 8'd4, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/chs_fan_pwm_array.md
Name: chs_fan_pwm_array

Overview:
- Multi-channel fan/actuator PWM generator for the cool/heat subsystem of the smart-home design.
- Generalises the single-channel fixed-width fan-speed PWM: channel count and duty width are parametrised.
- Each channel ramps its applied duty toward its target at a controlled rate instead of jumping.
- Per-channel enable and a per-channel state machine are added. Sits between the mode/power decoder and the fan drivers.

Parameters:
CH, 2, number of independent PWM channels (1..8)
WIDTH, 8, duty/counter width in bits (4..12); MAX = 2^WIDTH-1
STEP, 4, duty increment/decrement per ramp tick (1..MAX)
RAMP_PERIODS, 4, PWM periods between ramp ticks (>=1)
KICK_PERIODS, 8, PWM periods of full-duty kick (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
arst  in  1  asynchronous reset, active-low
en  in  CH  per-channel enable; level-sensitive
speed  in  CH*WIDTH  per-channel target duty; channel i in bits [i*WIDTH +: WIDTH]
pwm_data  out  CH  PWM outputs
duty  out  CH*WIDTH  currently applied duty per channel
busy  out  CH  channel in a ramp or kick state
period_tick  out  1  one-cycle pulse on the last cycle of each PWM period

Behaviour:
- Reset (arst=0): all state cleared asynchronously.
  - pwm_data=0, duty=0, busy=0, period_tick=0.
  - Period counter = 0, ramp counter = 0, all channels in OFF.
- Period counter:
  - Shared by all channels; counts 0..MAX-1 and wraps, so period = MAX clocks.
  - period_tick = (cnt == MAX-1).
- PWM output:
  - pwm_data[i] = registered (cnt < applied_duty[i]).
  - duty=0 gives constant low; duty=MAX gives constant high.
  - Output lags cnt by one clock.
- Ramp counter:
  - Counts period_ticks 0..RAMP_PERIODS-1.
  - ramp_tick = period_tick AND ramp counter == RAMP_PERIODS-1.
- Duty updates:
  - Applied duty changes only at a period_tick, so it is effective from cnt=0 of the next period; no glitched periods.
  - en and speed are sampled at the ramp_tick only.
- Effective target: tgt[i] = en[i] ? speed[i] : 0.
- Per-channel FSM (evaluated on ramp_tick):
  - OFF: duty=0. If tgt>0, go to UP (to KICK when the feature is enabled).
  - UP:
    - duty += min(STEP, tgt-duty).
    - If the new duty == tgt, go to STEADY.
    - If tgt < duty, go to DOWN.
  - DOWN:
    - duty -= min(STEP, duty-tgt).
    - If the new duty == tgt, go to STEADY, or to OFF when tgt==0.
    - If tgt > duty, go to UP.
  - STEADY:
    - If tgt > duty, go to UP; if tgt < duty, go to DOWN; the same tick applies the first step.
    - If tgt==0 and duty==0, go to OFF.
- Arithmetic: never overshoots the target and never wraps. Computed in WIDTH+1 bits, then saturated to 0..MAX.
- busy[i] = 1 in UP, DOWN or KICK; 0 in OFF or STEADY.
- Target change mid-ramp: direction re-evaluated at each ramp_tick; reversal costs no extra tick.
- en deassert: treated as tgt=0; channel ramps down, it is not cut immediately.
- Reset mid-ramp: the next state after release is OFF with duty=0; the counters restart at 0 one clock after release.
- Channels are fully independent; simultaneous events on different channels do not interact.

Optional Feature:
- Macro: CHS_KICKSTART_EN.
- Defined: OFF with tgt>0 at a ramp_tick goes to KICK.
  - Applied duty = MAX for KICK_PERIODS full periods, counted by a per-channel period_tick counter.
  - On expiry: duty = min(STEP, tgt); go to UP, or STEADY if already equal.
  - If tgt becomes 0 during KICK (checked every period_tick), duty = 0 and go to OFF at that period_tick.
- Undefined: no KICK state or kick counter is synthesised; OFF goes directly to UP.

Test Plan:
- Reset: arst=0 while running with duty=0x80 → pwm_data=0, duty=0, busy=0 immediately. Release → channels OFF, first period_tick after 255 clocks (WIDTH=8).
- Ramp up: en=1, speed0=0x10, STEP=4, RAMP_PERIODS=4 (feature off) → duty0 steps 4,8,12,16 at successive ramp_ticks (every 1020 clocks). busy0 high until STEADY. pwm_data0 high 16 of 255 clocks per period.
- Boundaries: speed=0xFF steady → pwm_data constant 1. speed=0 steady → constant 0. Non-multiple target 0x0A with STEP=4 → duty 4,8,10, no overshoot.
- Reversal and disable: during a ramp to 0x40 at duty 0x20, set speed=0x10 → next ramp_tick duty 0x1C, state DOWN. Then en=0 → ramps to 0, OFF, busy=0.
- Independence: ch0 ramps up while ch1 ramps down in the same ramp_ticks → each follows its own sequence. Mid-period speed change has no effect until the ramp_tick.
- CHS_KICKSTART_EN: OFF→speed=0x08 → duty=0xFF for 8 periods, then duty=4, UP, then 8. Clear en during the kick → duty 0 and OFF at the next period_tick.
